// File: rtl/spi_xfer_ctrl.sv
// SPI transaction controller: TX/RX byte buffers around a handshake FSM that drives a byte-level SPI master.
// Define SPI_XFER_TIMEOUT_EN to build the watchdog on the byte handshake.

module spi_xfer_ctrl #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic                   sysClk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   cs_n,
  output logic                   m_tx_en,
  output logic [7:0]             m_tx_byte,
  input  logic                   m_byte_complete,
  input  logic [7:0]             m_rx_byte
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1 || TIMEOUT < 2) begin : g_param_check
    $error("spi_xfer_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT_RISE, WAIT_FALL, GAP, FINISH} state_t;

  state_t          state, next_state;
  logic [2:0]      bc_sync;
  logic            rise, fall, timeout, start_ok;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   remaining;
  logic [7:0]      tx_mem [DEPTH];
  logic [AW-1:0]   tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0]   tx_count;
  logic            tx_push, tx_pop;
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   rx_wr_ptr, rx_rd_ptr, rx_waddr;
  logic            rx_push, rx_pop, rx_ovw;
  logic            cs_n_d, m_tx_en_d, busy_d, done_d, err_d;

  // bc_sync[1] is the synchronized flag, bc_sync[2] its previous value for edge detection
  always_ff @(posedge sysClk or posedge reset)
    if (reset) bc_sync <= '0;
    else       bc_sync <= {bc_sync[1:0], m_byte_complete};

  assign rise     = bc_sync[1] & ~bc_sync[2];
  assign fall     = ~bc_sync[1] & bc_sync[2];
  assign start_ok = (len != '0) && (len <= tx_count);

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  always_ff @(posedge sysClk or posedge reset)
    if (reset)
      wd_cnt <= '0;
    else if ((state == WAIT_RISE || state == WAIT_FALL) && next_state == state)
      wd_cnt <= wd_cnt + TW'(1);
    else
      wd_cnt <= '0;

  assign timeout = (state == WAIT_RISE || state == WAIT_FALL) && (wd_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sysClk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next_state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start && start_ok) next_state = SETUP;
      SETUP,
      GAP:       if (gap_cnt == GAP_LAST) next_state = SEND;
      SEND:      next_state = WAIT_RISE;
      WAIT_RISE: if (rise) next_state = WAIT_FALL;
      WAIT_FALL: if (fall) next_state = (remaining == CW'(1)) ? FINISH : GAP;
      FINISH:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    if (timeout) next_state = IDLE;
  end

  // Outputs are decoded from next_state and registered so the master sees glitch-free enables
  always_comb begin
    tx_pop    = (state == IDLE && next_state == SETUP) || (state == WAIT_FALL && next_state == GAP);
    rx_push   = (state == WAIT_FALL) && fall && !timeout;
    cs_n_d    = (next_state == IDLE) || (next_state == FINISH);
    m_tx_en_d = !(next_state == SEND || next_state == WAIT_RISE || next_state == WAIT_FALL);
    busy_d    = !((next_state == IDLE) || (next_state == FINISH));
    done_d    = (next_state == FINISH);
    err_d     = (state == IDLE && start && !start_ok) || timeout;
  end

  always_ff @(posedge sysClk or posedge reset)
    if (reset) begin
      cs_n      <= 1'b1;
      m_tx_en   <= 1'b1;
      m_tx_byte <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cs_n    <= cs_n_d;
      m_tx_en <= m_tx_en_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      if (tx_pop) m_tx_byte <= tx_mem[tx_rd_ptr];
    end

  always_ff @(posedge sysClk or posedge reset)
    if (reset) begin
      gap_cnt   <= '0;
      remaining <= '0;
    end else begin
      if ((state == SETUP || state == GAP) && next_state == state) gap_cnt <= gap_cnt + GW'(1);
      else                                                          gap_cnt <= '0;
      if (state == IDLE && next_state == SETUP) remaining <= len;
      else if (rx_push)                         remaining <= remaining - CW'(1);
    end

  // A watchdog expiry flushes the TX buffer so a stale transaction cannot be replayed
  assign tx_push = wr_en && (tx_count != FULL) && !timeout;

  always_ff @(posedge sysClk)
    if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;

  always_ff @(posedge sysClk or posedge reset)
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (timeout) begin
      tx_rd_ptr <= tx_wr_ptr;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end

  // A push into a full RX buffer replaces the newest byte instead of advancing
  assign rx_pop   = rd_en && (rx_count != '0);
  assign rx_ovw   = rx_push && (rx_count == FULL) && !rx_pop;
  assign rx_waddr = rx_ovw ? rx_wr_ptr - AW'(1) : rx_wr_ptr;

  always_ff @(posedge sysClk)
    if (rx_push) rx_mem[rx_waddr] <= m_rx_byte;

  always_ff @(posedge sysClk or posedge reset)
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rd_data   <= '0;
    end else begin
      if (rx_push && !rx_ovw) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + AW'(1);
        rd_data   <= rx_mem[rx_rd_ptr];
      end
      rx_count <= rx_count + CW'(rx_push && !rx_ovw) - CW'(rx_pop);
    end

endmodule
